// File: rtl/uart_receiver_param.sv
// Oversampled UART receiver with configurable data/parity/stop framing, a single
// output word register with ready/valid handshake, and registered error pulses.
module uart_receiver_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam logic [TW-1:0] HALF_LAST  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic          PAR_TARGET = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state;
  state_t next_state;

  logic                 sync1;
  logic                 sync2;
  logic                 rxs;
  logic [TW-1:0]        tick_cnt;
  logic [TW-1:0]        tick_last;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 half_hit;
  logic                 full_hit;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_low;
  logic                 frame_done;
  logic                 parity_ok;

  // The synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  assign rxs       = sync2;
  assign tick_last = (state == S_START) ? HALF_LAST : FULL_LAST;
  assign half_hit  = sample_tick && (tick_cnt == HALF_LAST);
  assign full_hit  = sample_tick && (tick_cnt == FULL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (sample_tick && !rxs) begin
          next_state = S_START;
        end
      end
      S_START: begin
        if (half_hit) begin
          next_state = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full_hit && (bit_cnt == DATA_LAST)) begin
          next_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (full_hit) begin
          next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (full_hit) begin
          if (!rxs) begin
            next_state = S_BREAK;
          end else if (bit_cnt == STOP_LAST) begin
            next_state = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (sample_tick && rxs) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    shift_en   = (state == S_DATA) && full_hit;
    par_en     = (state == S_PARITY) && full_hit;
    stop_low   = (state == S_STOP) && full_hit && !rxs;
    frame_done = (state == S_STOP) && full_hit && rxs && (bit_cnt == STOP_LAST);
  end

  // Counters restart on every state change and stay parked in IDLE/BREAK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (sample_tick) begin
      if ((state != next_state) || (state == S_IDLE) || (state == S_BREAK)) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tick_cnt == tick_last) begin
        tick_cnt <= '0;
        bit_cnt  <= bit_cnt + BW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg <= {rxs, shreg[DATA_BITS-1:1]};
      end
      if (par_en) begin
        par_bit <= rxs;
      end
    end
  end

  assign parity_ok = (PARITY_MODE == 0) || (((^shreg) ^ par_bit) == PAR_TARGET);

  // A good frame only lands when the register is free or being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= frame_done && !parity_ok;
      frame_err   <= stop_low;
      overrun_err <= frame_done && parity_ok && dout_valid && !dout_ready;
      if (frame_done && parity_ok && (!dout_valid || dout_ready)) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver_param.sv
// Bench for uart_receiver_param: a frame-outcome model scheduled by tick number,
// checked every cycle, plus literal expectations on a default and a 7O2 instance.
`timescale 1ns/1ps
module tb_uart_receiver_param;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;

  typedef enum int {EV_GOOD, EV_PARITY, EV_FRAME} ev_kind_t;
  typedef struct {
    int       t;
    ev_kind_t kind;
    logic [8:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx_a, rx_b;
  logic       ready_a, ready_b;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a, ovr_b, busy_a, busy_b;

  int checks = 0;
  int passes = 0;
  int tick_num = 0;
  int target = 0;
  int n_perr_a = 0, n_ferr_a = 0, n_ovr_a = 0;

  logic [8:0] exp_dout  [2];
  logic       exp_valid [2];
  logic       exp_perr  [2];
  logic       exp_ferr  [2];
  logic       exp_ovr   [2];
  ev_t q_a[$];
  ev_t q_b[$];

  uart_receiver_param dut_a (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_a),
    .dout(dout_a), .dout_valid(valid_a), .dout_ready(ready_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_receiver_param #(
    .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(16)
  ) dut_b (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_b),
    .dout(dout_b), .dout_valid(valid_b), .dout_ready(ready_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic int dbits(input int d);
    return (d == 0) ? 8 : 7;
  endfunction

  function automatic int pmode(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int sbits(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, got, want, $time);
    end
  endtask

  // Applies whatever frame outcome is due on this tick, then the consumer handshake.
  task automatic model_step(input int d, input logic rdy);
    ev_t  ev;
    logic have;
    logic loaded;
    have   = 1'b0;
    loaded = 1'b0;
    exp_perr[d] = 1'b0;
    exp_ferr[d] = 1'b0;
    exp_ovr[d]  = 1'b0;
    if (sample_tick) begin
      if (d == 0 && q_a.size() > 0 && q_a[0].t == tick_num) begin
        ev = q_a.pop_front();
        have = 1'b1;
      end
      if (d == 1 && q_b.size() > 0 && q_b[0].t == tick_num) begin
        ev = q_b.pop_front();
        have = 1'b1;
      end
    end
    if (have) begin
      case (ev.kind)
        EV_FRAME:  exp_ferr[d] = 1'b1;
        EV_PARITY: exp_perr[d] = 1'b1;
        default: begin
          if (!exp_valid[d] || rdy) begin
            exp_dout[d]  = ev.data;
            exp_valid[d] = 1'b1;
            loaded       = 1'b1;
          end else begin
            exp_ovr[d] = 1'b1;
          end
        end
      endcase
    end
    if (!loaded && rdy) begin
      exp_valid[d] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int d = 0; d < 2; d++) begin
          exp_dout[d]  = '0;
          exp_valid[d] = 1'b0;
          exp_perr[d]  = 1'b0;
          exp_ferr[d]  = 1'b0;
          exp_ovr[d]   = 1'b0;
        end
        q_a.delete();
        q_b.delete();
      end else begin
        model_step(0, ready_a);
        model_step(1, ready_b);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("a.dout_valid", 9'(valid_a), 9'(exp_valid[0]));
      checkOutput("a.dout", 9'(dout_a), exp_dout[0]);
      checkOutput("a.parity_err", 9'(perr_a), 9'(exp_perr[0]));
      checkOutput("a.frame_err", 9'(ferr_a), 9'(exp_ferr[0]));
      checkOutput("a.overrun_err", 9'(ovr_a), 9'(exp_ovr[0]));
      checkOutput("b.dout_valid", 9'(valid_b), 9'(exp_valid[1]));
      checkOutput("b.dout", 9'(dout_b), exp_dout[1]);
      checkOutput("b.parity_err", 9'(perr_b), 9'(exp_perr[1]));
      checkOutput("b.frame_err", 9'(ferr_b), 9'(exp_ferr[1]));
      checkOutput("b.overrun_err", 9'(ovr_b), 9'(exp_ovr[1]));
    end
  end

  always @(posedge clk) begin
    if (perr_a) n_perr_a <= n_perr_a + 1;
    if (ferr_a) n_ferr_a <= n_ferr_a + 1;
    if (ovr_a)  n_ovr_a  <= n_ovr_a + 1;
  end

  // Starts and ends on a negedge; the tick lands on the last posedge of the slot.
  task automatic one_tick(input logic val, input logic rdy_pulse);
    if (target == 0) rx_a = val; else rx_b = val;
    for (int c = 0; c < TICK_DIV; c++) begin
      sample_tick = (c == TICK_DIV - 1);
      if (c == TICK_DIV - 1 && rdy_pulse) begin
        if (target == 0) ready_a = 1'b1; else ready_b = 1'b1;
      end
      @(negedge clk);
    end
    sample_tick = 1'b0;
    if (rdy_pulse) begin
      if (target == 0) ready_a = 1'b0; else ready_b = 1'b0;
    end
    tick_num++;
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) one_tick(1'b1, 1'b0);
  endtask

  task automatic consume(input int d);
    if (d == 0) ready_a = 1'b1; else ready_b = 1'b1;
    @(negedge clk);
    if (d == 0) ready_a = 1'b0; else ready_b = 1'b0;
  endtask

  task automatic applyStimulus(input int d, input logic [8:0] data, input logic par,
                               input logic [1:0] stops, input logic rdy_at_done,
                               input int abort_at);
    int   dw, pw, sw, t0, bad_j;
    logic px, pbad, val;
    ev_t  ev;
    dw = dbits(d);
    pw = (pmode(d) != 0) ? 1 : 0;
    sw = sbits(d);
    target = d;
    t0 = tick_num;
    bad_j = -1;
    for (int j = sw - 1; j >= 0; j--) if (!stops[j]) bad_j = j;
    px = 1'b0;
    for (int i = 0; i < dw; i++) px = px ^ data[i];
    pbad = (pw == 1) && ((px ^ par) != (pmode(d) == 2));
    ev.data = (d == 0) ? (data & 9'h0FF) : (data & 9'h07F);
    if (bad_j >= 0) begin
      ev.kind = EV_FRAME;
      ev.t    = t0 + OS / 2 + OS * (1 + dw + pw + bad_j);
    end else begin
      ev.kind = pbad ? EV_PARITY : EV_GOOD;
      ev.t    = t0 + OS / 2 + OS * (dw + pw + sw);
    end
    if (abort_at < 0) begin
      if (d == 0) q_a.push_back(ev); else q_b.push_back(ev);
    end
    for (int b = 0; b < 1 + dw + pw + sw; b++) begin
      if (b == 0) val = 1'b0;
      else if (b <= dw) val = data[b-1];
      else if (pw == 1 && b == dw + 1) val = par;
      else val = stops[b - 1 - dw - pw];
      for (int k = 0; k < OS; k++) begin
        if (abort_at >= 0 && tick_num - t0 >= abort_at) return;
        one_tick(val, rdy_at_done && (tick_num == ev.t));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time %0t, required completion before 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap_p, snap_f, snap_o;
    reset = 1'b1;
    sample_tick = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset dout_a", 9'(dout_a), 9'h000);
    checkOutput("reset valid_a", 9'(valid_a), 9'h000);
    checkOutput("reset busy_a", 9'(busy_a), 9'h000);
    checkOutput("reset busy_b", 9'(busy_b), 9'h000);
    reset = 1'b0;
    idle_ticks(6);

    // 0xA5, even parity 0
    $display("[TB] frame 0xA5 good");
    snap_p = n_perr_a;
    applyStimulus(0, 9'h0A5, 1'b0, 2'b11, 1'b0, -1);
    checkOutput("A5 dout", 9'(dout_a), 9'h0A5);
    checkOutput("A5 valid", 9'(valid_a), 9'h001);
    checkOutput("A5 no parity_err", 9'(n_perr_a - snap_p), 9'h000);
    consume(0);
    checkOutput("A5 consumed", 9'(valid_a), 9'h000);
    idle_ticks(4);

    // 0x3C with wrong even parity bit
    $display("[TB] frame 0x3C parity error");
    snap_p = n_perr_a;
    applyStimulus(0, 9'h03C, 1'b1, 2'b11, 1'b0, -1);
    checkOutput("3C parity_err pulses", 9'(n_perr_a - snap_p), 9'h001);
    checkOutput("3C valid", 9'(valid_a), 9'h000);
    checkOutput("3C dout kept", 9'(dout_a), 9'h0A5);
    idle_ticks(4);

    // 0x55 with stop low and line held low for three bit times
    $display("[TB] frame 0x55 framing error and break");
    snap_f = n_ferr_a;
    applyStimulus(0, 9'h055, 1'b0, 2'b10, 1'b0, -1);
    repeat (2 * OS) one_tick(1'b0, 1'b0);
    checkOutput("break busy", 9'(busy_a), 9'h001);
    checkOutput("55 frame_err pulses", 9'(n_ferr_a - snap_f), 9'h001);
    one_tick(1'b1, 1'b0);
    checkOutput("break released", 9'(busy_a), 9'h000);
    idle_ticks(8);
    applyStimulus(0, 9'h012, 1'b0, 2'b11, 1'b0, -1);
    checkOutput("12 dout", 9'(dout_a), 9'h012);
    checkOutput("12 valid", 9'(valid_a), 9'h001);
    consume(0);
    idle_ticks(4);

    // short low glitch
    $display("[TB] 4-tick glitch");
    repeat (4) one_tick(1'b0, 1'b0);
    idle_ticks(20);
    checkOutput("glitch busy", 9'(busy_a), 9'h000);
    checkOutput("glitch valid", 9'(valid_a), 9'h000);

    // back-to-back with no consumer, then with ready at the second completion
    $display("[TB] back-to-back overrun");
    snap_o = n_ovr_a;
    applyStimulus(0, 9'h001, 1'b1, 2'b11, 1'b0, -1);
    applyStimulus(0, 9'h002, 1'b1, 2'b11, 1'b0, -1);
    checkOutput("overrun dout kept", 9'(dout_a), 9'h001);
    checkOutput("overrun pulses", 9'(n_ovr_a - snap_o), 9'h001);
    consume(0);
    idle_ticks(4);
    snap_o = n_ovr_a;
    applyStimulus(0, 9'h001, 1'b1, 2'b11, 1'b0, -1);
    applyStimulus(0, 9'h002, 1'b1, 2'b11, 1'b1, -1);
    checkOutput("ready replace dout", 9'(dout_a), 9'h002);
    checkOutput("ready replace valid", 9'(valid_a), 9'h001);
    checkOutput("ready replace no overrun", 9'(n_ovr_a - snap_o), 9'h000);

    // 7 data bits, odd parity, two stops; then reset in the middle of DATA
    $display("[TB] 7O2 instance");
    applyStimulus(1, 9'h041, 1'b1, 2'b11, 1'b0, -1);
    checkOutput("b 41 dout", 9'(dout_b), 9'h041);
    checkOutput("b 41 valid", 9'(valid_b), 9'h001);
    applyStimulus(1, 9'h05A, 1'b1, 2'b11, 1'b0, OS / 2 + 3 * OS);
    checkOutput("b busy mid-frame", 9'(busy_b), 9'h001);
    rx_b = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("b reset dout", 9'(dout_b), 9'h000);
    checkOutput("b reset valid", 9'(valid_b), 9'h000);
    checkOutput("b reset busy", 9'(busy_b), 9'h000);
    checkOutput("b reset errs", 9'({perr_b, ferr_b, ovr_b}), 9'h000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_ticks(24);
    checkOutput("b after reset busy", 9'(busy_b), 9'h000);
    checkOutput("b after reset valid", 9'(valid_b), 9'h000);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
